// File: rtl/ram_dp_be.sv
// Simple dual-port RAM, single clock: byte-lane writes, 1- or 2-cycle pipelined reads
// with a valid strobe, selectable read-during-write policy and a one-word-per-cycle clear engine.
module ram_dp_be #(
    parameter int MEM_WIDTH  = 16,
    parameter int MEM_DEPTH  = 1024,
    parameter int ADDR_SIZE  = 10,
    parameter int BYTE_W     = 8,
    parameter int RD_LATENCY = 1,
    parameter int RDW_MODE   = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          blk_select,
    input  logic                          wr_en,
    input  logic [MEM_WIDTH/BYTE_W-1:0]   be,
    input  logic [ADDR_SIZE-1:0]          addr_wr,
    input  logic [MEM_WIDTH-1:0]          din,
    input  logic                          rd_en,
    input  logic [ADDR_SIZE-1:0]          addr_rd,
    output logic [MEM_WIDTH-1:0]          dout,
    output logic                          dout_valid,
    input  logic                          clr_req,
    output logic                          busy
);
    localparam int NB = MEM_WIDTH / BYTE_W;
    localparam logic [ADDR_SIZE:0]   DEPTH_W   = (ADDR_SIZE+1)'(MEM_DEPTH);
    localparam logic [ADDR_SIZE-1:0] LAST_ADDR = ADDR_SIZE'(MEM_DEPTH - 1);

    typedef enum logic {IDLE, CLEAR} state_t;

    logic [MEM_WIDTH-1:0] mem [MEM_DEPTH];

    state_t               state_q;
    logic [ADDR_SIZE-1:0] clr_addr_q;
    logic                 busy_q;

    logic                 wr_acc, rd_acc, rd_in_range, clr_we;
    logic [MEM_WIDTH-1:0] old_word, merged_word;
    logic [MEM_WIDTH-1:0] s1_data_d, s1_data_q;
    logic                 s1_vld_d, s1_vld_q;

    assign wr_acc      = blk_select & wr_en & ~busy_q & ({1'b0, addr_wr} < DEPTH_W);
    assign rd_acc      = blk_select & rd_en & ~busy_q;
    assign rd_in_range = ({1'b0, addr_rd} < DEPTH_W);
    // The word in flight at a reset edge is left untouched.
    assign clr_we      = (state_q == CLEAR) & ~rst;
    assign busy        = busy_q;

    always_comb begin
        old_word    = rd_in_range ? mem[addr_rd] : '0;
        merged_word = old_word;
        for (int i = 0; i < NB; i++) begin
            if (be[i]) merged_word[i*BYTE_W +: BYTE_W] = din[i*BYTE_W +: BYTE_W];
        end
    end

    // Forwarding only applies when the same in-range address is written this cycle.
    always_comb begin
        s1_vld_d  = rd_acc;
        s1_data_d = s1_data_q;
        if (rd_acc) begin
            if (RDW_MODE == 1 && wr_acc && addr_wr == addr_rd && rd_in_range)
                s1_data_d = merged_word;
            else
                s1_data_d = old_word;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld_q  <= 1'b0;
            s1_data_q <= '0;
        end else begin
            s1_vld_q  <= s1_vld_d;
            s1_data_q <= s1_data_d;
        end
    end

    // Array is never reset; clear engine and user writes are mutually exclusive via busy.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr_q] <= '0;
        end else if (wr_acc) begin
            for (int i = 0; i < NB; i++) begin
                if (be[i]) mem[addr_wr][i*BYTE_W +: BYTE_W] <= din[i*BYTE_W +: BYTE_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            clr_addr_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (clr_req) begin
                        state_q    <= CLEAR;
                        busy_q     <= 1'b1;
                        clr_addr_q <= '0;
                    end
                end
                CLEAR: begin
                    if (clr_addr_q == LAST_ADDR) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        clr_addr_q <= clr_addr_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    generate
        if (RD_LATENCY == 2) begin : g_lat2
            logic [MEM_WIDTH-1:0] out_data_d, out_data_q;
            logic                 out_vld_q;

            always_comb out_data_d = s1_vld_q ? s1_data_q : out_data_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    out_vld_q  <= 1'b0;
                    out_data_q <= '0;
                end else begin
                    out_vld_q  <= s1_vld_q;
                    out_data_q <= out_data_d;
                end
            end

            assign dout       = out_data_q;
            assign dout_valid = out_vld_q;
        end else begin : g_lat1
            assign dout       = s1_data_q;
            assign dout_valid = s1_vld_q;
        end
    endgenerate
endmodule

// File: tb/tb_ram_dp_be.sv
// Directed bench for ram_dp_be: two instances (latency 1 / old-data, latency 2 / new-data)
// share one stimulus stream; a shadow memory feeds per-instance expected-read queues.
module tb_ram_dp_be;
    localparam int W = 16;
    localparam int D = 1024;
    localparam int A = 10;

    logic         clk = 1'b0;
    logic         rst, blk, wr_en, rd_en, clr_req;
    logic [1:0]   be;
    logic [A-1:0] addr_wr, addr_rd;
    logic [W-1:0] din;
    logic [W-1:0] dout_a, dout_b;
    logic         vld_a, vld_b, busy_a, busy_b;

    always #5 clk = ~clk;

    ram_dp_be #(.MEM_WIDTH(W), .MEM_DEPTH(D), .ADDR_SIZE(A), .BYTE_W(8),
                .RD_LATENCY(1), .RDW_MODE(0)) dut_a (
        .clk(clk), .rst(rst), .blk_select(blk), .wr_en(wr_en), .be(be),
        .addr_wr(addr_wr), .din(din), .rd_en(rd_en), .addr_rd(addr_rd),
        .dout(dout_a), .dout_valid(vld_a), .clr_req(clr_req), .busy(busy_a));

    ram_dp_be #(.MEM_WIDTH(W), .MEM_DEPTH(D), .ADDR_SIZE(A), .BYTE_W(8),
                .RD_LATENCY(2), .RDW_MODE(1)) dut_b (
        .clk(clk), .rst(rst), .blk_select(blk), .wr_en(wr_en), .be(be),
        .addr_wr(addr_wr), .din(din), .rd_en(rd_en), .addr_rd(addr_rd),
        .dout(dout_b), .dout_valid(vld_b), .clr_req(clr_req), .busy(busy_b));

    typedef struct {
        int           due;
        logic [W-1:0] data;
    } exp_t;

    exp_t         qa[$], qb[$];
    logic [W-1:0] mm [D];
    logic [W-1:0] lasta, lastb;
    int           mbusy = 0, ptr = 0, cyc = 0;
    int           checks = 0, errors = 0;
    logic         started = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %h exp %h cyc %0d", tag, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin : mon
        logic ev;
        exp_t e;
        if (started) begin
            while (qa.size() > 0 && qa[0].due < cyc) void'(qa.pop_front());
            ev = qa.size() > 0 && qa[0].due == cyc;
            chk("vld_a", W'(vld_a), W'(ev));
            if (ev) begin e = qa.pop_front(); lasta = e.data; end
            chk("dout_a", dout_a, lasta);

            while (qb.size() > 0 && qb[0].due < cyc) void'(qb.pop_front());
            ev = qb.size() > 0 && qb[0].due == cyc;
            chk("vld_b", W'(vld_b), W'(ev));
            if (ev) begin e = qb.pop_front(); lastb = e.data; end
            chk("dout_b", dout_b, lastb);
        end
    end

    function automatic logic [W-1:0] merge(input logic [W-1:0] o, input logic [W-1:0] d,
                                           input logic [1:0] bb);
        logic [W-1:0] m = o;
        for (int i = 0; i < 2; i++) if (bb[i]) m[i*8 +: 8] = d[i*8 +: 8];
        return m;
    endfunction

    task automatic step(input logic r, input logic b_sel, input logic w, input logic [1:0] bb,
                        input int aw, input logic [W-1:0] d, input logic rd, input int ar,
                        input logic c);
        logic wa, ra, wasb;
        logic [W-1:0] old;
        exp_t e;
        rst = r; blk = b_sel; wr_en = w; be = bb; addr_wr = aw[A-1:0]; din = d;
        rd_en = rd; addr_rd = ar[A-1:0]; clr_req = c;
        wasb = (mbusy > 0);
        wa = !r && b_sel && w && !wasb;
        ra = !r && b_sel && rd && !wasb;
        if (ra) begin
            old = mm[ar];
            e.due = cyc + 1; e.data = old;
            qa.push_back(e);
            e.due = cyc + 2; e.data = (wa && aw == ar) ? merge(old, d, bb) : old;
            qb.push_back(e);
        end
        @(posedge clk);
        #1;
        if (r) begin
            mbusy = 0;
            qa.delete(); qb.delete();
            lasta = '0; lastb = '0;
        end else if (wasb) begin
            mm[ptr] = '0;
            ptr++;
            mbusy--;
        end else begin
            if (wa) mm[aw] = merge(mm[aw], d, bb);
            if (c) begin mbusy = D; ptr = 0; end
        end
        chk("busy_a", W'(busy_a), W'(mbusy != 0));
        chk("busy_b", W'(busy_b), W'(mbusy != 0));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 2'b00, 0, '0, 0, 0, 0);
    endtask
    task automatic wr(input int a, input logic [W-1:0] d, input logic [1:0] bb);
        step(0, 1, 1, bb, a, d, 0, 0, 0);
    endtask
    task automatic rd(input int a);
        step(0, 1, 0, 2'b00, 0, '0, 1, a, 0);
    endtask
    task automatic wrd(input int aw, input logic [W-1:0] d, input logic [1:0] bb, input int ar);
        step(0, 1, 1, bb, aw, d, 1, ar, 0);
    endtask

    initial begin
        for (int i = 0; i < D; i++) mm[i] = 'x;
        lasta = '0; lastb = '0;

        // reset, then a full clear so contents are known
        step(1, 0, 0, 2'b00, 0, '0, 0, 0, 0);
        step(1, 0, 0, 2'b00, 0, '0, 0, 0, 0);
        started = 1'b1;
        idle(2);
        step(0, 0, 0, 2'b00, 0, '0, 0, 0, 1);
        idle(D + 1);
        rd(5);
        idle(3);

        // byte-lane writes
        wr(3, 16'hABCD, 2'b11);
        wr(3, 16'h1200, 2'b10);
        rd(3);
        wr(3, 16'hFFFF, 2'b00);
        rd(3);
        idle(3);

        // back-to-back reads
        wr(0, 16'h0001, 2'b11);
        wr(1, 16'h0002, 2'b11);
        wr(2, 16'h0003, 2'b11);
        rd(0); rd(1); rd(2);
        idle(4);

        // read-during-write
        wr(7, 16'h1111, 2'b11);
        wrd(7, 16'h2222, 2'b11, 7);
        rd(7);
        wr(8, 16'h1111, 2'b11);
        wrd(8, 16'hAB00, 2'b10, 8);
        rd(8);
        wrd(9, 16'h3333, 2'b11, 7);
        rd(9);
        idle(3);

        // fill, then clear with a same-cycle access; accesses during busy are ignored
        for (int a = 0; a < D; a++) wr(a, 16'h5A00 ^ 16'(a), 2'b11);
        rd(1023); rd(0);
        step(0, 1, 1, 2'b11, 4, 16'hBEEF, 1, 4, 1);
        for (int k = 0; k < D; k++) begin
            if (k < 8) step(0, 1, 1, 2'b11, 1023 - k, 16'hFFFF, 1, k, 0);
            else       idle(1);
        end
        rd(0); rd(1023); rd(4); rd(512);
        idle(3);

        // reset mid-clear
        for (int a = 0; a < 12; a++) wr(a, 16'hC000 | 16'(a + 1), 2'b11);
        wr(100, 16'h7777, 2'b11);
        step(0, 0, 0, 2'b00, 0, '0, 0, 0, 1);
        idle(10);
        step(1, 0, 0, 2'b00, 0, '0, 0, 0, 0);
        for (int a = 0; a < 10; a++) rd(a);
        rd(11); rd(100);
        step(0, 0, 1, 2'b11, 100, 16'h0BAD, 0, 0, 0);
        rd(100);
        idle(4);

        checks++;
        assert (qa.size() == 0 && qb.size() == 0) else begin
            errors++;
            $error("FAIL drain got %0d/%0d exp 0/0", qa.size(), qb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
